// File: rtl/alu_op_pkg.sv
// Shared opcodes, controller state type and scan-counter sizing for the ALU op sequencer.
package alu_op_pkg;

  localparam logic [1:0] OP_SUB       = 2'd0;
  localparam logic [1:0] OP_NAND      = 2'd1;
  localparam logic [1:0] OP_LEAD_ONES = 2'd2;
  localparam logic [1:0] OP_ONEHOT    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough to hold any count or index in 0..2*width.
  function automatic int scan_cnt_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/alu_bit_scanner.sv
// Serial bit scanner for LEAD_ONES (mode 0, MSB first) and ONEHOT (mode 1, LSB first).
// Result outputs reflect the final bit during the cycle o_done is high.
module alu_bit_scanner
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [2*WIDTH-1:0] i_c,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_y,
  output logic               o_overflow,
  output logic               o_err
);

  localparam int CW = scan_cnt_w(WIDTH);

  logic [2*WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [CW-1:0]      pos_q, pos_d;
  logic [CW-1:0]      acc_q, acc_d;
  logic               seen_q, seen_d;
  logic               err_q, err_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               bit_cur;

  assign bit_cur = mode_q ? sh_q[0] : sh_q[2*WIDTH-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q   <= '0;
      rem_q  <= '0;
      pos_q  <= '0;
      acc_q  <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      pos_q  <= pos_d;
      acc_q  <= acc_d;
      seen_q <= seen_d;
      err_q  <= err_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    sh_d   = sh_q;
    rem_d  = rem_q;
    pos_d  = pos_q;
    acc_d  = acc_q;
    seen_d = seen_q;
    err_d  = err_q;
    mode_d = mode_q;
    busy_d = busy_q;
    if (i_start) begin
      sh_d   = i_c;
      rem_d  = CW'(2 * WIDTH);
      pos_d  = '0;
      acc_d  = '0;
      seen_d = 1'b0;
      err_d  = 1'b0;
      mode_d = i_mode;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = mode_q ? (sh_q >> 1) : (sh_q << 1);
      pos_d = pos_q + 1'b1;
      rem_d = rem_q - 1'b1;
      // seen_q means "first zero seen" for LEAD_ONES, "first one seen" for ONEHOT.
      if (mode_q) begin
        if (bit_cur) begin
          if (!seen_q) begin
            acc_d  = pos_q;
            seen_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        if (!bit_cur) begin
          seen_d = 1'b1;
        end else if (!seen_q) begin
          acc_d = acc_q + 1'b1;
        end
      end
      if (rem_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  assign o_done     = busy_q && (rem_q == CW'(1));
  assign o_y        = WIDTH'(acc_d);
  assign o_overflow = |(acc_d >> WIDTH);
  assign o_err      = err_d;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: valid/ready controller for SUB, NAND, LEAD_ONES and ONEHOT.
// Optional sticky status flags are built when ALU_OP_SEQUENCER_STICKY_EN is defined.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_overflow,
  output logic             o_err,
  input  logic             i_clr,
  output logic             o_sticky_ovf,
  output logic             o_sticky_err
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic signed [WIDTH-1:0] a_s, b_s, diff_s;

  logic             scan_start;
  logic             scan_done;
  logic [WIDTH-1:0] scan_y;
  logic             scan_ovf;
  logic             scan_err;

  // Two's-complement subtract overflow: operand signs differ and result sign follows B.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (a[WIDTH-1] != d[WIDTH-1]);
  endfunction

  assign a_s    = i_a;
  assign b_s    = i_b;
  assign diff_s = a_s - b_s;

  alu_bit_scanner #(
    .WIDTH(WIDTH)
  ) u_scanner (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (scan_start),
    .i_mode    (i_op == OP_ONEHOT),
    .i_c       ({i_b, i_a}),
    .o_done    (scan_done),
    .o_y       (scan_y),
    .o_overflow(scan_ovf),
    .o_err     (scan_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    scan_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          case (i_op)
            OP_SUB: begin
              y_d     = diff_s;
              ovf_d   = sub_ovf(a_s, b_s, diff_s);
              err_d   = 1'b0;
              state_d = DONE;
            end
            OP_NAND: begin
              y_d     = ~(i_a & i_b);
              ovf_d   = 1'b0;
              err_d   = 1'b0;
              state_d = DONE;
            end
            default: begin
              scan_start = 1'b1;
              state_d    = SCAN;
            end
          endcase
        end
      end
      SCAN: begin
        if (scan_done) begin
          y_d     = scan_y;
          ovf_d   = scan_ovf;
          err_d   = scan_err;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_y        = y_q;
  assign o_overflow = ovf_q;
  assign o_err      = err_q;

`ifdef ALU_OP_SEQUENCER_STICKY_EN
  logic sticky_ovf_q;
  logic sticky_err_q;
  logic res_hs;

  assign res_hs = o_valid && i_ready;

  // A flagged handshake takes priority over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_ovf_q <= 1'b0;
      sticky_err_q <= 1'b0;
    end else begin
      if (res_hs && ovf_q) begin
        sticky_ovf_q <= 1'b1;
      end else if (i_clr) begin
        sticky_ovf_q <= 1'b0;
      end
      if (res_hs && err_q) begin
        sticky_err_q <= 1'b1;
      end else if (i_clr) begin
        sticky_err_q <= 1'b0;
      end
    end
  end

  assign o_sticky_ovf = sticky_ovf_q;
  assign o_sticky_err = sticky_err_q;
`else
  logic unused_clr;
  assign unused_clr   = i_clr;
  assign o_sticky_ovf = 1'b0;
  assign o_sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (WIDTH=4): behavioural model plus directed vectors.
module tb_alu_op_sequencer;

  localparam int W = 4;
`ifdef ALU_OP_SEQUENCER_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_y;
  logic         o_overflow;
  logic         o_err;
  logic         i_clr;
  logic         o_sticky_ovf;
  logic         o_sticky_err;

  int vectors = 0;
  int miscompares = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_y         (o_y),
    .o_overflow  (o_overflow),
    .o_err       (o_err),
    .i_clr       (i_clr),
    .o_sticky_ovf(o_sticky_ovf),
    .o_sticky_err(o_sticky_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] e_y;
  bit           e_ovf, e_err;
  bit           m_busy;
  int           m_wait;
  bit           s_ovf, s_err;

  function automatic void model_result(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, output logic [W-1:0] y,
                                       output bit ovf, output bit err, output int lat);
    logic [2*W-1:0] c;
    logic signed [W-1:0] sa, sb;
    int d, n, idx;
    bit found;
    c = {b, a};
    sa = a;
    sb = b;
    err = 1'b0;
    ovf = 1'b0;
    lat = 1;
    case (op)
      2'd0: begin
        d   = int'(sa) - int'(sb);
        y   = W'(d);
        ovf = (d > (2 ** (W - 1)) - 1) || (d < -(2 ** (W - 1)));
      end
      2'd1: y = ~(a & b);
      2'd2: begin
        n = 0;
        for (int i = 2 * W - 1; i >= 0; i--) begin
          if (!c[i]) break;
          n++;
        end
        y   = W'(n);
        ovf = n > (2 ** W) - 1;
        lat = 2 * W + 1;
      end
      default: begin
        idx = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
          if (c[i]) begin
            if (!found) begin
              idx = i;
              found = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
        end
        y   = W'(idx);
        ovf = idx > (2 ** W) - 1;
        lat = 2 * W + 1;
      end
    endcase
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    bit hs;
    int lat;
    if (!i_rst_n) begin
      m_busy = 1'b0;
      m_wait = 0;
      s_ovf  = 1'b0;
      s_err  = 1'b0;
    end else begin
      hs = m_busy && (m_wait == 0) && i_ready;
`ifdef ALU_OP_SEQUENCER_STICKY_EN
      s_ovf = (hs && e_ovf) ? 1'b1 : (i_clr ? 1'b0 : s_ovf);
      s_err = (hs && e_err) ? 1'b1 : (i_clr ? 1'b0 : s_err);
`endif
      if (!m_busy) begin
        if (i_valid) begin
          model_result(i_op, i_a, i_b, e_y, e_ovf, e_err, lat);
          m_busy = 1'b1;
          m_wait = lat - 1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (hs) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    chk("ready", o_ready, !m_busy);
    chk("valid", o_valid, m_busy && (m_wait == 0));
    if (m_busy && (m_wait == 0)) begin
      chk("y", o_y, e_y);
      chk("ovf", o_overflow, e_ovf);
      chk("err", o_err, e_err);
    end
    chk("sticky_ovf", o_sticky_ovf, s_ovf);
    chk("sticky_err", o_sticky_err, s_err);
  end

  // ---------------- directed vectors ----------------
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ey, input bit eo, input bit ee, input int elat,
                        input int hold, input bit clr_at_hs);
    int n;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_a     = W'($urandom);
    i_b     = W'($urandom);
    n = 1;
    while (!o_valid && n < 30) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("latency", n, elat);
    chk("lit_y", o_y, ey);
    chk("lit_ovf", o_overflow, eo);
    chk("lit_err", o_err, ee);
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1;
      i_op    = 2'($urandom);
      @(posedge i_clk); #1;
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_y", o_y, ey);
      chk("hold_ovf", o_overflow, eo);
      chk("hold_err", o_err, ee);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_clr   = clr_at_hs;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    i_clr   = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_op    = 2'd0;
    i_a     = '0;
    i_b     = '0;
    i_ready = 1'b0;
    i_clr   = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_y", o_y, 4'h0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_sticky", {o_sticky_ovf, o_sticky_err}, 2'b00);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op(2'd0, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1, 0, 1'b0);
    chk("stk_after_sub_ovf", o_sticky_ovf, STK);
    run_op(2'd1, 4'b1100, 4'b1010, 4'b0111, 1'b0, 1'b0, 1, 0, 1'b0);
    chk("stk_after_nand", o_sticky_ovf, STK);
    @(posedge i_clk); #1;
    i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    chk("stk_after_clr", o_sticky_ovf, 1'b0);

    run_op(2'd0, 4'd5, 4'd7, 4'b1110, 1'b0, 1'b0, 1, 3, 1'b0);
    run_op(2'd2, 4'b0000, 4'b1110, 4'd3, 1'b0, 1'b0, 9, 0, 1'b0);
    run_op(2'd2, 4'b1111, 4'b1111, 4'd8, 1'b0, 1'b0, 9, 2, 1'b0);
    run_op(2'd3, 4'b0100, 4'b0000, 4'd2, 1'b0, 1'b0, 9, 0, 1'b0);
    run_op(2'd3, 4'b0001, 4'b0001, 4'd0, 1'b0, 1'b1, 9, 0, 1'b0);
    chk("stk_err_set", o_sticky_err, STK);
    run_op(2'd3, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 9, 0, 1'b0);

    // Flagged handshake together with a clear: the set must win.
    run_op(2'd0, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1, 0, 1'b1);
    chk("stk_set_wins", o_sticky_ovf, STK);

    // Reset in the middle of a scan.
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_op    = 2'd2;
    i_a     = 4'b0000;
    i_b     = 4'b1111;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("midscan_rst_valid", o_valid, 1'b0);
    chk("midscan_rst_ready", o_ready, 1'b1);
    chk("midscan_rst_y", o_y, 4'h0);
    chk("midscan_rst_sticky", {o_sticky_ovf, o_sticky_err}, 2'b00);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op(2'd0, 4'd5, 4'd7, 4'b1110, 1'b0, 1'b0, 1, 0, 1'b0);

    repeat (2) @(posedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
